// File: rtl/fma16_arb.sv
// Two-requester round-robin front end for a shared fma16 datapath.
// One operation in flight; operands are held on fma_* for LATENCY cycles, then the result is returned.
module fma16_arb #(
  parameter int unsigned LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [2:0]  req0_op,
  input  logic [15:0] req0_x,
  input  logic [15:0] req0_y,
  input  logic [15:0] req0_z,
  input  logic [1:0]  req0_rm,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [2:0]  req1_op,
  input  logic [15:0] req1_x,
  input  logic [15:0] req1_y,
  input  logic [15:0] req1_z,
  input  logic [1:0]  req1_rm,
  output logic        rsp0_valid,
  input  logic        rsp0_ready,
  output logic [15:0] rsp0_result,
  output logic        rsp0_err,
  output logic        rsp1_valid,
  input  logic        rsp1_ready,
  output logic [15:0] rsp1_result,
  output logic        rsp1_err,
  output logic [15:0] fma_x,
  output logic [15:0] fma_y,
  output logic [15:0] fma_z,
  output logic        fma_mul,
  output logic        fma_add,
  output logic        fma_negr,
  output logic        fma_negz,
  output logic [1:0]  fma_rm,
  input  logic [15:0] fma_result
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

  state_e            state_q, state_d;
  logic              lastGrant_q;
  logic              owner_q;
  logic [3:0]        cnt_q;
  logic [15:0]       x_q, y_q, z_q;
  logic [1:0]        rm_q;
  logic [3:0]        ctl_q;
  logic [1:0]        rspValid_q;
  logic [1:0]        rspErr_q;
  logic [1:0][15:0]  rspResult_q;

  logic              grant1;
  logic              accept;
  logic              illegal;
  logic [3:0]        ctlDec;
  logic [2:0]        selOp;
  logic              respReady;

  // Requester 1 wins only if requester 0 is absent or was served last.
  always_comb begin
    grant1     = req1_valid && (!req0_valid || !lastGrant_q);
    req0_ready = reset_n && (state_q == IDLE) && req0_valid && !grant1;
    req1_ready = reset_n && (state_q == IDLE) && grant1;
    accept     = req0_ready || req1_ready;
    selOp      = grant1 ? req1_op : req0_op;
    respReady  = owner_q ? rsp1_ready : rsp0_ready;
    illegal    = 1'b0;
    ctlDec     = 4'b0000;
    case (selOp)
      3'b000:  ctlDec = 4'b0100;
      3'b001:  ctlDec = 4'b0101;
      3'b010:  ctlDec = 4'b1000;
      3'b011:  ctlDec = 4'b1100;
      3'b100:  ctlDec = 4'b1101;
      3'b101:  ctlDec = 4'b1110;
      3'b110:  ctlDec = 4'b1111;
      default: illegal = 1'b1;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = illegal ? RESP : EXEC;
      EXEC:    if (cnt_q == 4'd0) state_d = RESP;
      RESP:    if (respReady) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Illegal opcodes skip the datapath, leaving the previous operands on fma_*.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lastGrant_q <= 1'b1;
      owner_q     <= 1'b0;
      cnt_q       <= 4'd0;
      x_q         <= '0;
      y_q         <= '0;
      z_q         <= '0;
      rm_q        <= '0;
      ctl_q       <= '0;
      rspValid_q  <= '0;
      rspErr_q    <= '0;
      rspResult_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (accept) begin
          lastGrant_q <= grant1;
          owner_q     <= grant1;
          if (illegal) begin
            rspValid_q[grant1]  <= 1'b1;
            rspErr_q[grant1]    <= 1'b1;
            rspResult_q[grant1] <= 16'h7E00;
          end else begin
            x_q   <= grant1 ? req1_x : req0_x;
            y_q   <= grant1 ? req1_y : req0_y;
            z_q   <= grant1 ? req1_z : req0_z;
            rm_q  <= grant1 ? req1_rm : req0_rm;
            ctl_q <= ctlDec;
            cnt_q <= 4'(LATENCY - 1);
          end
        end
        EXEC: if (cnt_q == 4'd0) begin
          rspValid_q[owner_q]  <= 1'b1;
          rspErr_q[owner_q]    <= 1'b0;
          rspResult_q[owner_q] <= fma_result;
        end else begin
          cnt_q <= cnt_q - 4'd1;
        end
        RESP: if (respReady) begin
          rspValid_q[owner_q]  <= 1'b0;
          rspErr_q[owner_q]    <= 1'b0;
          rspResult_q[owner_q] <= '0;
        end
        default: ;
      endcase
    end
  end

  assign fma_x       = x_q;
  assign fma_y       = y_q;
  assign fma_z       = z_q;
  assign fma_rm      = rm_q;
  assign {fma_mul, fma_add, fma_negr, fma_negz} = ctl_q;
  assign rsp0_valid  = rspValid_q[0];
  assign rsp1_valid  = rspValid_q[1];
  assign rsp0_err    = rspErr_q[0];
  assign rsp1_err    = rspErr_q[1];
  assign rsp0_result = rspResult_q[0];
  assign rsp1_result = rspResult_q[1];

endmodule
